reaction_timer_multi: RTL and testbench

REACTION_TIMER_MULTI -- requirements
Module: reaction_timer_multi

---
 rtl/reaction_timer_multi.sv | 142 ++++++++++++++
 tb/tb_reaction_timer_multi.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/reaction_timer_multi.sv
// reaction_timer_multi: multi-round reaction-time game with random wait, BCD ms counter and best-score tracking.
module reaction_timer_multi #(
    parameter int CLK_HZ       = 100_000_000,
    parameter int ROUNDS       = 4,
    parameter int MIN_WAIT_MS  = 1000,
    parameter int WAIT_SPAN_MS = 4096,
    parameter int HOLD_MS      = 2000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       enter,
    output logic       led_r,
    output logic       led_g,
    output logic       led_b,
    output logic [3:0] d0,
    output logic [3:0] d1,
    output logic [3:0] d2,
    output logic [3:0] d3,
    output logic [3:0] round_idx,
    output logic       done,
    output logic       false_start
);
    localparam int DIV = CLK_HZ / 1000;
    localparam int PW  = DIV > 1 ? $clog2(DIV) : 1;

    typedef enum logic [2:0] {IDLE, RWAIT, REACT, SHOW, FALSE, DONE} state_t;

    state_t      state, state_n;
    logic [PW-1:0] pre, pre_n;
    logic [15:0] lfsr, cnt, cnt_n, result, result_n, best, best_n, disp;
    logic [31:0] tmr, tmr_n, wait_ms;
    logic [3:0]  round_n;
    logic        tick, expire;

    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < 4; i++)
            if (c) begin
                if (v[4*i +: 4] == 4'd9) r[4*i +: 4] = 4'd0;
                else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        return r;
    endfunction

    assign tick    = pre == PW'(DIV - 1);
    assign expire  = tick && tmr <= 32'd1;
    assign wait_ms = 32'(MIN_WAIT_MS) + 32'(lfsr & 16'(WAIT_SPAN_MS - 1));

    // One timer serves both the random wait and the display hold.
    always_comb begin
        state_n  = state;
        tmr_n    = tick ? tmr - 32'd1 : tmr;
        cnt_n    = cnt;
        result_n = result;
        best_n   = best;
        round_n  = round_idx;
        case (state)
            IDLE, DONE:
                if (start) begin
                    state_n = RWAIT;
                    tmr_n   = wait_ms;
                    round_n = 4'd0;
                    best_n  = 16'h9999;
                end
            RWAIT:
                if (enter) begin
                    state_n = FALSE;
                    tmr_n   = 32'(HOLD_MS);
                end else if (expire) begin
                    state_n = REACT;
                    cnt_n   = 16'h0;
                end
            REACT:
                if (enter || cnt == 16'h9999) begin
                    state_n  = SHOW;
                    result_n = cnt;
                    tmr_n    = 32'(HOLD_MS);
                    if (cnt < best) best_n = cnt;
                end else if (tick) cnt_n = bcd_inc(cnt);
            SHOW:
                if (expire) begin
                    if (round_idx == 4'(ROUNDS - 1)) state_n = DONE;
                    else begin
                        state_n = RWAIT;
                        round_n = round_idx + 4'd1;
                        tmr_n   = wait_ms;
                    end
                end
            FALSE:
                if (expire) begin
                    state_n = RWAIT;
                    tmr_n   = wait_ms;
                end
            default: state_n = IDLE;
        endcase
        pre_n = (state_n != state || tick) ? '0 : pre + 1'b1;
        disp  = state_n == REACT ? cnt_n :
                state_n == SHOW  ? result_n :
                state_n == FALSE ? 16'hEEEE :
                state_n == DONE  ? best_n : 16'h0;
    end

    // Outputs are registered from next-state values so they line up with the state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            pre              <= '0;
            lfsr             <= 16'hACE1;
            cnt              <= 16'h0;
            result           <= 16'h0;
            best             <= 16'h9999;
            tmr              <= 32'd0;
            round_idx        <= 4'd0;
            {led_r, led_g, led_b} <= 3'b000;
            {d3, d2, d1, d0} <= 16'h0;
            done             <= 1'b0;
            false_start      <= 1'b0;
        end else begin
            state            <= state_n;
            pre              <= pre_n;
            lfsr             <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            cnt              <= cnt_n;
            result           <= result_n;
            best             <= best_n;
            tmr              <= tmr_n;
            round_idx        <= round_n;
            led_r            <= state_n == RWAIT || state_n == FALSE;
            led_g            <= state_n == REACT || state_n == DONE;
            led_b            <= state_n == SHOW || state_n == FALSE || state_n == DONE;
            {d3, d2, d1, d0} <= disp;
            done             <= state_n == DONE;
            false_start      <= state_n == FALSE;
        end
    end
endmodule

// File: tb/tb_reaction_timer_multi.sv
// tb_reaction_timer_multi: directed scenario tests for reaction_timer_multi at 1 kHz clock.
module tb_reaction_timer_multi;
    logic       clk = 1'b0, rst = 1'b1, start = 1'b0, enter = 1'b0;
    logic       led_r, led_g, led_b, done, false_start;
    logic [3:0] d0, d1, d2, d3, round_idx;
    logic [15:0] m_lfsr;
    wire  [15:0] disp = {d3, d2, d1, d0};
    wire  [2:0]  leds = {led_r, led_g, led_b};
    int n_cmp = 0, n_bad = 0;

    reaction_timer_multi #(.CLK_HZ(1000), .ROUNDS(2), .MIN_WAIT_MS(2), .WAIT_SPAN_MS(4), .HOLD_MS(3)) dut (
        .clk(clk), .rst(rst), .start(start), .enter(enter),
        .led_r(led_r), .led_g(led_g), .led_b(led_b),
        .d0(d0), .d1(d1), .d2(d2), .d3(d3),
        .round_idx(round_idx), .done(done), .false_start(false_start)
    );

    always #5 clk = ~clk;

    // Reference LFSR: taps 16,14,13,11, seed ACE1, free-running outside reset.
    always @(posedge clk) m_lfsr <= rst ? 16'hACE1 : {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, got hang want finish");
        $fatal(1);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic count_while(input logic [2:0] lv, output int n);
        n = 0;
        while (leds === lv && n < 50) begin
            n++;
            cyc();
        end
    endtask

    task automatic wait_leds(input logic [2:0] lv, input int lim, output int n);
        n = 0;
        while (leds !== lv && n < lim) begin
            n++;
            cyc();
        end
    endtask

    task automatic wait_disp(input logic [15:0] v, input int lim);
        int n = 0;
        while (disp !== v && n < lim) begin
            n++;
            cyc();
        end
    endtask

    function automatic int exp_wait();
        return 2 + int'(m_lfsr & 16'h3);
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) cyc();
        n_cmp++; if (leds !== 3'b000) begin n_bad++; $display("FAIL reset_leds: got %b want 000", leds); end
        n_cmp++; if (disp !== 16'h0) begin n_bad++; $display("FAIL reset_disp: got %h want 0000", disp); end
        n_cmp++; if ({round_idx, done, false_start} !== 6'b0) begin n_bad++; $display("FAIL reset_misc: got %b want 000000", {round_idx, done, false_start}); end
        rst = 1'b0;
        cyc();
    endtask

    task automatic test_session();
        int n, w;
        w = exp_wait(); start = 1'b1; cyc(); start = 1'b0;
        n_cmp++; if (leds !== 3'b100 || round_idx !== 4'd0) begin n_bad++; $display("FAIL rwait_entry: leds=%b round=%0d want 100/0", leds, round_idx); end
        count_while(3'b100, n);
        n_cmp++; if (n !== w) begin n_bad++; $display("FAIL wait_len0: got %0d want %0d", n, w); end
        n_cmp++; if (leds !== 3'b010 || disp !== 16'h0) begin n_bad++; $display("FAIL react_entry: leds=%b disp=%h want 010/0000", leds, disp); end
        cyc();
        n_cmp++; if (disp !== 16'h0001) begin n_bad++; $display("FAIL count1: got %h want 0001", disp); end
        cyc();
        n_cmp++; if (disp !== 16'h0002) begin n_bad++; $display("FAIL count2: got %h want 0002", disp); end
        wait_disp(16'h0037, 100);
        enter = 1'b1; cyc(); enter = 1'b0;
        n_cmp++; if (leds !== 3'b001 || disp !== 16'h0037 || round_idx !== 4'd0) begin n_bad++; $display("FAIL show0: leds=%b disp=%h round=%0d want 001/0037/0", leds, disp, round_idx); end
        cyc(); cyc();
        n_cmp++; if (leds !== 3'b001) begin n_bad++; $display("FAIL show0_hold: leds=%b want 001", leds); end
        w = exp_wait(); cyc();
        n_cmp++; if (leds !== 3'b100 || round_idx !== 4'd1) begin n_bad++; $display("FAIL round1_entry: leds=%b round=%0d want 100/1", leds, round_idx); end
        count_while(3'b100, n);
        n_cmp++; if (n !== w) begin n_bad++; $display("FAIL wait_len1: got %0d want %0d", n, w); end
        wait_disp(16'h0012, 100);
        enter = 1'b1; cyc(); enter = 1'b0;
        n_cmp++; if (leds !== 3'b001 || disp !== 16'h0012) begin n_bad++; $display("FAIL show1: leds=%b disp=%h want 001/0012", leds, disp); end
        repeat (3) cyc();
        n_cmp++; if (leds !== 3'b011 || disp !== 16'h0012 || done !== 1'b1) begin n_bad++; $display("FAIL done: leds=%b disp=%h done=%b want 011/0012/1", leds, disp, done); end
    endtask

    task automatic test_false_start_and_ignore();
        int n, w;
        start = 1'b1; cyc(); start = 1'b0;
        n_cmp++; if (leds !== 3'b100 || round_idx !== 4'd0 || done !== 1'b0) begin n_bad++; $display("FAIL restart: leds=%b round=%0d done=%b want 100/0/0", leds, round_idx, done); end
        enter = 1'b1; cyc(); enter = 1'b0;
        n_cmp++; if (false_start !== 1'b1 || disp !== 16'hEEEE || leds !== 3'b101 || round_idx !== 4'd0) begin n_bad++; $display("FAIL false_entry: fs=%b disp=%h leds=%b round=%0d want 1/eeee/101/0", false_start, disp, leds, round_idx); end
        cyc(); cyc();
        n_cmp++; if (false_start !== 1'b1) begin n_bad++; $display("FAIL false_hold: fs=%b want 1", false_start); end
        w = exp_wait(); cyc();
        n_cmp++; if (leds !== 3'b100 || false_start !== 1'b0 || round_idx !== 4'd0) begin n_bad++; $display("FAIL false_exit: leds=%b fs=%b round=%0d want 100/0/0", leds, false_start, round_idx); end
        count_while(3'b100, n);
        n_cmp++; if (n !== w) begin n_bad++; $display("FAIL wait_after_false: got %0d want %0d", n, w); end
        wait_disp(16'h0005, 100);
        start = 1'b1; cyc(); start = 1'b0;
        n_cmp++; if (leds !== 3'b010 || disp !== 16'h0006) begin n_bad++; $display("FAIL start_in_react: leds=%b disp=%h want 010/0006", leds, disp); end
        wait_disp(16'h0020, 100);
        enter = 1'b1; cyc(); enter = 1'b0;
        n_cmp++; if (disp !== 16'h0020 || leds !== 3'b001) begin n_bad++; $display("FAIL show_20: disp=%h leds=%b want 0020/001", disp, leds); end
        wait_leds(3'b010, 20, n);
        wait_disp(16'h0030, 100);
        enter = 1'b1; cyc(); enter = 1'b0;
        repeat (3) cyc();
        n_cmp++; if (disp !== 16'h0020 || done !== 1'b1) begin n_bad++; $display("FAIL best_20: disp=%h done=%b want 0020/1", disp, done); end
    endtask

    task automatic test_coincident();
        int w;
        w = exp_wait(); start = 1'b1; cyc(); start = 1'b0;
        repeat (w - 1) cyc();
        n_cmp++; if (leds !== 3'b100) begin n_bad++; $display("FAIL pre_expiry: leds=%b want 100", leds); end
        enter = 1'b1; cyc(); enter = 1'b0;
        n_cmp++; if (false_start !== 1'b1 || disp !== 16'hEEEE) begin n_bad++; $display("FAIL coincident: fs=%b disp=%h want 1/eeee", false_start, disp); end
    endtask

    task automatic test_saturation();
        int n;
        rst = 1'b1; cyc(); rst = 1'b0;
        start = 1'b1; cyc(); start = 1'b0;
        wait_leds(3'b010, 20, n);
        wait_leds(3'b001, 10100, n);
        n_cmp++; if (n !== 10000 || disp !== 16'h9999) begin n_bad++; $display("FAIL saturate: cycles=%0d disp=%h want 10000/9999", n, disp); end
        wait_leds(3'b010, 20, n);
        wait_disp(16'h9999, 10100);
        n_cmp++; if (leds !== 3'b010) begin n_bad++; $display("FAIL at_9999: leds=%b want 010", leds); end
        enter = 1'b1; cyc(); enter = 1'b0;
        n_cmp++; if (leds !== 3'b001 || disp !== 16'h9999) begin n_bad++; $display("FAIL enter_9999: leds=%b disp=%h want 001/9999", leds, disp); end
        repeat (3) cyc();
        n_cmp++; if (done !== 1'b1 || disp !== 16'h9999) begin n_bad++; $display("FAIL best_9999: done=%b disp=%h want 1/9999", done, disp); end
    endtask

    task automatic test_reset_mid();
        int n, w;
        start = 1'b1; cyc(); start = 1'b0;
        wait_leds(3'b010, 20, n);
        wait_disp(16'h0050, 100);
        n_cmp++; if (disp !== 16'h0050 || leds !== 3'b010) begin n_bad++; $display("FAIL at_50: disp=%h leds=%b want 0050/010", disp, leds); end
        rst = 1'b1; start = 1'b1; enter = 1'b1; cyc();
        rst = 1'b0; start = 1'b0; enter = 1'b0;
        n_cmp++; if ({leds, disp, round_idx, done, false_start} !== 25'b0) begin n_bad++; $display("FAIL rst_mid: leds=%b disp=%h round=%0d done=%b fs=%b want all 0", leds, disp, round_idx, done, false_start); end
        cyc();
        n_cmp++; if (leds !== 3'b000) begin n_bad++; $display("FAIL idle_after_rst: leds=%b want 000", leds); end
        w = exp_wait(); start = 1'b1; enter = 1'b1; cyc(); start = 1'b0; enter = 1'b0;
        n_cmp++; if (leds !== 3'b100 || false_start !== 1'b0 || round_idx !== 4'd0) begin n_bad++; $display("FAIL start_enter_idle: leds=%b fs=%b round=%0d want 100/0/0", leds, false_start, round_idx); end
        count_while(3'b100, n);
        n_cmp++; if (n !== w) begin n_bad++; $display("FAIL wait_after_rst: got %0d want %0d", n, w); end
    endtask

    initial begin
        test_reset();
        test_session();
        test_false_start_and_ignore();
        test_coincident();
        test_saturation();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
